// File: rtl/vga_timing_decoder_if.sv
// vga_timing_decoder_if: raw VGA timing bundle (HS, VS, blank).
// master drives the three timing lines, slave samples them.
interface vga_timing_decoder_if;
    logic HS;
    logic VS;
    logic blank;

    modport master (output HS, output VS, output blank);
    modport slave  (input  HS, input  VS, input  blank);
endinterface

// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder: recovers per-pixel x/y from sampled HS/VS/blank,
// measures line/frame geometry and tracks timing lock.
// Ports: pixel_clk, rst (sync, active-high), vga (HS/VS/blank slave),
//   de/x/y pixel qualifier and coordinates, frame_start pulse,
//   h_total/v_total/h_active/v_active measurements, locked, sync_err pulse.
module vga_timing_decoder #(
    parameter bit          SPP         = 1'b0,
    parameter int unsigned LOCK_FRAMES = 3,
    parameter int unsigned CW          = 11
) (
    input  logic                pixel_clk,
    input  logic                rst,
    vga_timing_decoder_if.slave vga,
    output logic                de,
    output logic [CW-1:0]       x,
    output logic [CW-1:0]       y,
    output logic                frame_start,
    output logic [CW-1:0]       h_total,
    output logic [CW-1:0]       v_total,
    output logic [CW-1:0]       h_active,
    output logic [CW-1:0]       v_active,
    output logic                locked,
    output logic                sync_err
);
    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] CMAX       = '1;
    localparam logic [3:0]    MATCH_LAST = 4'(LOCK_FRAMES - 1);

    logic          hs_dly_q, hs_dly_d;
    logic          vs_dly_q, vs_dly_d;
    logic          blank_dly_q, blank_dly_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic [CW-1:0] h_total_q, h_total_d;
    logic [CW-1:0] v_total_q, v_total_d;
    logic [CW-1:0] h_active_q, h_active_d;
    logic [CW-1:0] v_active_q, v_active_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          de_q, de_d;
    logic          frame_start_q, frame_start_d;
    logic [CW-1:0] ref_h_q, ref_h_d;
    logic [CW-1:0] ref_v_q, ref_v_d;
    logic [3:0]    match_q, match_d;
    state_t        state_q, state_d;
    logic          locked_q, locked_d;
    logic          sync_err_q, sync_err_d;

    logic          hs_lead;
    logic          vs_lead;
    logic          act_start;
    logic          act_end;
    logic          hsat;
    logic [CW-1:0] h_new;
    logic [CW-1:0] v_new;

    always_comb begin
        hs_lead   = (vga.HS == SPP) && (hs_dly_q != SPP);
        vs_lead   = (vga.VS == SPP) && (vs_dly_q != SPP);
        act_start = !vga.blank && blank_dly_q;
        act_end   = vga.blank && !blank_dly_q;
        hsat      = (hcnt_q == CMAX);
        // Values the measurement registers take this cycle; the lock
        // tracker compares against these, not the stale registers.
        h_new     = hs_lead ? hcnt_q + ONE : h_total_q;
        v_new     = lcnt_q + CW'(hs_lead);

        hs_dly_d      = vga.HS;
        vs_dly_d      = vga.VS;
        blank_dly_d   = vga.blank;
        hcnt_d        = hcnt_q;
        lcnt_d        = lcnt_q;
        h_total_d     = h_new;
        v_total_d     = v_total_q;
        h_active_d    = h_active_q;
        v_active_d    = v_active_q;
        x_d           = x_q;
        y_d           = y_q;
        de_d          = !vga.blank;
        frame_start_d = vs_lead;
        ref_h_d       = ref_h_q;
        ref_v_d       = ref_v_q;
        match_d       = match_q;
        state_d       = state_q;
        sync_err_d    = 1'b0;

        if (hs_lead) begin
            hcnt_d = '0;
        end else if (!hsat) begin
            hcnt_d = hcnt_q + ONE;
        end

        if (vs_lead) begin
            v_total_d = v_new;
            lcnt_d    = '0;
        end else if (hs_lead) begin
            lcnt_d = lcnt_q + ONE;
        end

        if (act_start) begin
            x_d = '0;
        end else if (!vga.blank) begin
            x_d = x_q + ONE;
        end

        if (act_end) begin
            h_active_d = x_q + ONE;
            y_d        = y_q + ONE;
        end

        // Frame boundary overrides a line end landing on the same cycle.
        if (vs_lead) begin
            v_active_d = y_q;
            y_d        = '0;
        end

        unique case (state_q)
            ST_UNLOCKED: begin
                if (vs_lead) begin
                    ref_h_d = h_new;
                    ref_v_d = v_new;
                    match_d = '0;
                    state_d = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE: begin
                if (hsat) begin
                    state_d = ST_UNLOCKED;
                end else if (vs_lead) begin
                    if (h_new == ref_h_q && v_new == ref_v_q) begin
                        match_d = match_q + 4'd1;
                        if (match_d == MATCH_LAST) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        ref_h_d = h_new;
                        ref_v_d = v_new;
                        match_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (hsat
                    || (hs_lead && h_new != ref_h_q)
                    || (vs_lead && v_new != ref_v_q)) begin
                    state_d    = ST_UNLOCKED;
                    sync_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
            end
        endcase

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hs_dly_q      <= ~SPP;
            vs_dly_q      <= ~SPP;
            blank_dly_q   <= 1'b1;
            hcnt_q        <= '0;
            lcnt_q        <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            h_active_q    <= '0;
            v_active_q    <= '0;
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            ref_h_q       <= '0;
            ref_v_q       <= '0;
            match_q       <= '0;
            state_q       <= ST_UNLOCKED;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            hs_dly_q      <= hs_dly_d;
            vs_dly_q      <= vs_dly_d;
            blank_dly_q   <= blank_dly_d;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            h_active_q    <= h_active_d;
            v_active_q    <= v_active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
            ref_h_q       <= ref_h_d;
            ref_v_q       <= ref_v_d;
            match_q       <= match_d;
            state_q       <= state_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = frame_start_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign h_active    = h_active_q;
    assign v_active    = v_active_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb_vga_timing_decoder: drives a scaled VGA-style raster into an SPP=0
// and an SPP=1 decoder and checks both against a frame-level model.
module tb_vga_timing_decoder;
    localparam int CW     = 11;
    localparam int LF     = 3;
    localparam int H_TOT  = 41;
    localparam int H_ACT  = 32;
    localparam int HS_BEG = 34;
    localparam int HS_END = 37;
    localparam int V_TOT  = 14;
    localparam int V_ACT  = 10;
    localparam int VS_BEG = 11;
    localparam int VS_END = 13;
    localparam int FRAME  = H_TOT * V_TOT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_decoder_if vif0 ();
    vga_timing_decoder_if vif1 ();

    logic          de0, fs0, lk0, se0;
    logic [CW-1:0] x0, y0, ht0, vt0, ha0, va0;
    logic          de1, fs1, lk1, se1;
    logic [CW-1:0] x1, y1, ht1, vt1, ha1, va1;

    vga_timing_decoder #(.SPP(1'b0), .LOCK_FRAMES(LF), .CW(CW)) dut0 (
        .pixel_clk(clk), .rst(rst), .vga(vif0),
        .de(de0), .x(x0), .y(y0), .frame_start(fs0),
        .h_total(ht0), .v_total(vt0), .h_active(ha0), .v_active(va0),
        .locked(lk0), .sync_err(se0)
    );

    vga_timing_decoder #(.SPP(1'b1), .LOCK_FRAMES(LF), .CW(CW)) dut1 (
        .pixel_clk(clk), .rst(rst), .vga(vif1),
        .de(de1), .x(x1), .y(y1), .frame_start(fs1),
        .h_total(ht1), .v_total(vt1), .h_active(ha1), .v_active(va1),
        .locked(lk1), .sync_err(se1)
    );

    int tests = 0;
    int fails = 0;

    // raster generator state
    int hpos = 0, vpos = 0, line_len = H_TOT;
    bit hs_kill = 0, vs_kill = 0;
    bit a_hs = 0, a_vs = 0, a_bl = 1;
    int px = 0, py = 0;
    bit d_hs_p = 0, d_vs_p = 0;
    int vs_edges = 0;
    int last_lead_cyc = 0;

    // model state
    int cyc = 0;
    bit m_ph, m_pv, m_pb;
    int last_hs_t, leads, run_len, ends;
    int m_de, m_fs, m_ht, m_vt, m_ha, m_va, m_lk, m_se;
    int m_st, m_rh, m_rv, m_mc;
    bit synced = 0;
    bit xy_chk = 0;
    int e_x, e_y;
    int se_cnt0 = 0, se0_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_cycle();
        @(negedge clk);
        a_hs = !hs_kill && hpos >= HS_BEG && hpos < HS_END;
        a_vs = !vs_kill && vpos >= VS_BEG && vpos < VS_END;
        a_bl = !(hpos < H_ACT && vpos < V_ACT);
        px = hpos;
        py = vpos;
        if (a_vs && !d_vs_p) vs_edges++;
        if (a_hs && !d_hs_p) last_lead_cyc = cyc + 1;
        d_hs_p = a_hs;
        d_vs_p = a_vs;
        vif0.HS = !a_hs;
        vif0.VS = !a_vs;
        vif0.blank = a_bl;
        vif1.HS = a_hs;
        vif1.VS = a_vs;
        vif1.blank = a_bl;
        hpos++;
        if (hpos >= line_len) begin
            hpos = 0;
            line_len = H_TOT;
            vpos = (vpos + 1) % V_TOT;
        end
    endtask

    task automatic drive_to(input int hx, input int vy);
        int n;
        n = 0;
        do begin
            drive_cycle();
            n++;
        end while (!(px == hx && py == vy) && n < 3 * FRAME);
        @(posedge clk);
        #2;
    endtask

    task automatic wait_lock(input string nm);
        int n;
        n = 0;
        while (!lk0 && n < 8 * FRAME) begin
            drive_cycle();
            n++;
        end
        chk({nm, ".lock_in_time"}, 32'(lk0), 1);
    endtask

    task automatic model_step();
        bit hl, vl, as_, ae, sat;
        int el, hn, vn, pe;
        if (rst) begin
            m_ph = 0; m_pv = 0; m_pb = 1;
            last_hs_t = cyc; leads = 0; run_len = 0; ends = 0;
            m_de = 0; m_fs = 0; m_ht = 0; m_vt = 0; m_ha = 0; m_va = 0;
            m_st = 0; m_rh = 0; m_rv = 0; m_mc = 0; m_lk = 0; m_se = 0;
            synced = 0; xy_chk = 1; e_x = 0; e_y = 0;
            return;
        end
        hl  = a_hs && !m_ph;
        vl  = a_vs && !m_pv;
        as_ = !a_bl && m_pb;
        ae  = a_bl && !m_pb;
        el  = cyc - last_hs_t;
        sat = (el >= 2048);
        hn  = hl ? (el >= 2048 ? 0 : el) : m_ht;
        vn  = (leads + (hl ? 1 : 0)) % 2048;
        m_se = 0;
        case (m_st)
            0: if (vl) begin m_rh = hn; m_rv = vn; m_mc = 0; m_st = 1; end
            1: begin
                if (sat) m_st = 0;
                else if (vl) begin
                    if (hn == m_rh && vn == m_rv) begin
                        m_mc++;
                        if (m_mc == LF - 1) m_st = 2;
                    end else begin
                        m_rh = hn; m_rv = vn; m_mc = 0;
                    end
                end
            end
            default: begin
                if (sat || (hl && hn != m_rh) || (vl && vn != m_rv)) begin
                    m_st = 0;
                    m_se = 1;
                end
            end
        endcase
        m_lk = (m_st == 2);
        if (hl) begin m_ht = hn; last_hs_t = cyc; end
        if (vl) begin m_vt = vn; leads = 0; end
        else if (hl) leads++;
        pe = ends;
        if (as_) run_len = 1;
        else if (!a_bl) run_len++;
        if (ae) begin m_ha = run_len % 2048; ends++; end
        if (vl) begin m_va = pe % 2048; ends = 0; synced = 1; end
        m_de = !a_bl;
        m_fs = vl;
        xy_chk = m_de && synced;
        e_x = px;
        e_y = py;
        m_ph = a_hs; m_pv = a_vs; m_pb = a_bl;
    endtask

    task automatic check_dut(input string t, input logic de,
                             input logic [CW-1:0] x, input logic [CW-1:0] y,
                             input logic fs, input logic [CW-1:0] ht,
                             input logic [CW-1:0] vt, input logic [CW-1:0] ha,
                             input logic [CW-1:0] va, input logic lk,
                             input logic se);
        chk({t, ".de"}, 32'(de), m_de);
        chk({t, ".frame_start"}, 32'(fs), m_fs);
        chk({t, ".h_total"}, 32'(ht), m_ht);
        chk({t, ".v_total"}, 32'(vt), m_vt);
        chk({t, ".h_active"}, 32'(ha), m_ha);
        chk({t, ".v_active"}, 32'(va), m_va);
        chk({t, ".locked"}, 32'(lk), m_lk);
        chk({t, ".sync_err"}, 32'(se), m_se);
        if (xy_chk) begin
            chk({t, ".x"}, 32'(x), e_x);
            chk({t, ".y"}, 32'(y), e_y);
        end
    endtask

    initial begin : compare
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            model_step();
            check_dut("d0", de0, x0, y0, fs0, ht0, vt0, ha0, va0, lk0, se0);
            check_dut("d1", de1, x1, y1, fs1, ht1, vt1, ha1, va1, lk1, se1);
            if (se0) begin
                se_cnt0++;
                se0_cyc = cyc;
            end
        end
    end

    initial begin : stim
        int se_base, n;
        vif0.HS = 1'b1; vif0.VS = 1'b1; vif0.blank = 1'b1;
        vif1.HS = 1'b0; vif1.VS = 1'b0; vif1.blank = 1'b1;

        // power-up reset, then lock on the 3rd full frame
        rst = 1'b1;
        repeat (10) drive_cycle();
        rst = 1'b0;
        vs_edges = 0;
        wait_lock("t1");
        chk("t1.lock_vs_edges", vs_edges, 4);
        chk("t1.d1_locked", 32'(lk1), 1);
        chk("t1.h_total", 32'(ht0), 41);
        chk("t1.v_total", 32'(vt0), 14);
        chk("t1.h_active", 32'(ha0), 32);
        chk("t1.v_active", 32'(va0), 10);
        chk("t1.d1_h_total", 32'(ht1), 41);
        chk("t1.d1_v_total", 32'(vt1), 14);
        chk("t1.no_sync_err", se_cnt0, 0);

        // coordinates at the corners of the visible area
        drive_to(0, 0);
        chk("t2.first_de", 32'(de0), 1);
        chk("t2.first_x", 32'(x0), 0);
        chk("t2.first_y", 32'(y0), 0);
        drive_to(H_ACT - 1, 0);
        chk("t2.eol_x", 32'(x0), 31);
        drive_to(0, 1);
        chk("t2.wrap_x", 32'(x0), 0);
        chk("t2.wrap_y", 32'(y0), 1);
        drive_to(H_ACT - 1, V_ACT - 1);
        chk("t2.last_x", 32'(x0), 31);
        chk("t2.last_y", 32'(y0), 9);
        chk("t2.d1_last_y", 32'(y1), 9);

        // one stretched line breaks lock
        drive_to(H_ACT, 3);
        line_len = H_TOT + 1;
        se_base = se_cnt0;
        n = 0;
        while (!se0 && n < 2 * FRAME) begin
            drive_cycle();
            n++;
        end
        chk("t3.sync_err_seen", 32'(se0), 1);
        chk("t3.d1_sync_err", 32'(se1), 1);
        chk("t3.h_total", 32'(ht0), 42);
        vs_edges = 0;
        drive_cycle();
        chk("t3.sync_err_width", 32'(se0), 0);
        chk("t3.unlocked", 32'(lk0), 0);
        wait_lock("t3");
        chk("t3.relock_vs_edges", vs_edges, 3);
        chk("t3.sync_err_count", se_cnt0 - se_base, 1);

        // sync lines stuck: hcnt saturation drops lock
        drive_to(H_TOT - 1, 4);
        hs_kill = 1;
        vs_kill = 1;
        synced = 0;
        se_base = se_cnt0;
        repeat (2100) drive_cycle();
        chk("t4.sat_latency", se0_cyc - last_lead_cyc, 2048);
        chk("t4.sync_err_count", se_cnt0 - se_base, 1);
        chk("t4.unlocked", 32'(lk0), 0);
        chk("t4.d1_unlocked", 32'(lk1), 0);
        hs_kill = 0;
        vs_kill = 0;
        wait_lock("t4");

        // reset in the middle of a visible line
        drive_to(10, 5);
        chk("t5.pre_de", 32'(de0), 1);
        rst = 1'b1;
        drive_cycle();
        @(posedge clk);
        #2;
        chk("t5.de", 32'(de0), 0);
        chk("t5.x", 32'(x0), 0);
        chk("t5.y", 32'(y0), 0);
        chk("t5.h_total", 32'(ht0), 0);
        chk("t5.v_active", 32'(va0), 0);
        chk("t5.locked", 32'(lk0), 0);
        chk("t5.d1_h_active", 32'(ha1), 0);
        rst = 1'b0;
        vs_edges = 0;
        wait_lock("t5");
        chk("t5.relock_vs_edges", vs_edges, 4);
        chk("t5.d1_locked", 32'(lk1), 1);
        chk("t5.v_total", 32'(vt0), 14);

        repeat (20) drive_cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
